// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL lock sequencer.
package pll_seq_pkg;

  typedef enum logic [1:0] {
    PLL_RESET = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } pll_seq_state_t;

  localparam int unsigned STAT_W = 8;

endpackage

// File: rtl/sync_bit.sv
// N-flop synchronizer for a single asynchronous bit; all flops reset to 0.
module sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) chain <= '0;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer on the free-running reference clock.
// Optional lock statistics counters enabled by defining PLL_LOCK_STATS_EN.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES        = 2,
  parameter int unsigned PLL_RST_CYCLES     = 16,
  parameter int unsigned LOCK_TIMEOUT       = 500000,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              locked,
  input  logic              pll_reconf_req,
  output logic              pll_rst,
  output logic              sys_reset,
  output logic              pll_ready,
  output logic [STAT_W-1:0] retry_count,
  output logic [STAT_W-1:0] loss_count
);

  localparam int unsigned CNT_MAX_A =
    (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned CNT_MAX =
    (CNT_MAX_A > LOCK_STABLE_CYCLES) ? CNT_MAX_A : LOCK_STABLE_CYCLES;
  localparam int unsigned CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);

  logic           locked_s;
  pll_seq_state_t state, state_nx;
  logic [CNT_W-1:0] cnt;

  sync_bit #(.STAGES(SYNC_STAGES)) u_locked_sync (
    .clk (refclk),
    .rst (rst),
    .d   (locked),
    .q   (locked_s)
  );

  always_comb begin
    state_nx = state;
    if (pll_reconf_req && state != PLL_RESET) begin
      state_nx = PLL_RESET;
    end else begin
      unique case (state)
        PLL_RESET: if (cnt == RST_LAST) state_nx = WAIT_LOCK;
        WAIT_LOCK: begin
          if (locked_s)                  state_nx = STABLE;
          else if (cnt == TIMEOUT_LAST)  state_nx = PLL_RESET;
        end
        STABLE: begin
          if (!locked_s)                 state_nx = WAIT_LOCK;
          else if (cnt == STABLE_LAST)   state_nx = RUN;
        end
        RUN:       if (!locked_s) state_nx = WAIT_LOCK;
        default:   state_nx = PLL_RESET;
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state     <= PLL_RESET;
      cnt       <= '0;
      pll_rst   <= 1'b1;
      sys_reset <= 1'b1;
      pll_ready <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= (state_nx != state) ? '0 : cnt + CNT_W'(1);
      pll_rst   <= (state_nx == PLL_RESET);
      sys_reset <= (state_nx != RUN);
      pll_ready <= (state_nx == RUN);
    end
  end

`ifdef PLL_LOCK_STATS_EN
  logic              retry_evt, loss_evt;
  logic [STAT_W-1:0] retry_q, loss_q;

  // A reconfigure request out of WAIT_LOCK also lands in PLL_RESET but is not a timeout.
  assign retry_evt = (state == WAIT_LOCK) && (state_nx == PLL_RESET) && !pll_reconf_req;
  assign loss_evt  = (state == RUN) && (state_nx == WAIT_LOCK);

  always_ff @(posedge refclk) begin
    if (rst) begin
      retry_q <= '0;
      loss_q  <= '0;
    end else begin
      if (retry_evt && retry_q != '1) retry_q <= retry_q + STAT_W'(1);
      if (loss_evt  && loss_q  != '1) loss_q  <= loss_q  + STAT_W'(1);
    end
  end

  assign retry_count = retry_q;
  assign loss_count  = loss_q;
`else
  assign retry_count = '0;
  assign loss_count  = '0;
`endif

endmodule
